// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write, read and issue bus of the scoreboarded register file
// Decode/writeback drive as master; the register file is the slave.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;
  logic              rd_busy0;
  logic              rd_busy1;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr0, rd_addr1, iss_en, iss_addr,
    input  rd_data0, rd_data1, rd_busy0, rd_busy1, pend_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr0, rd_addr1, iss_en, iss_addr,
    output rd_data0, rd_data1, rd_busy0, rd_busy1, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised 2R/1W register file with bypass and pending-write scoreboard
// Decode reads and issues; writeback writes and clears the pending bit.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;
  logic              iss_ok;

  logic [ADDR_W-1:0] port_addr [2];
  logic [DATA_W-1:0] port_val  [2];
  logic              port_busy [2];
  logic              zero_hit  [2];
  logic              fwd_hit   [2];

  assign wr_ok  = bus.wr_en  && !(ZR && bus.wr_addr  == '0);
  assign iss_ok = bus.iss_en && !(ZR && bus.iss_addr == '0);

  assign port_addr[0] = bus.rd_addr0;
  assign port_addr[1] = bus.rd_addr1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      zero_hit[p]  = ZR && port_addr[p] == '0;
      fwd_hit[p]   = BP && wr_ok && bus.wr_addr == port_addr[p];
      port_val[p]  = regs[port_addr[p]];
      port_busy[p] = pend[port_addr[p]] && !fwd_hit[p] && !zero_hit[p];
      if (zero_hit[p]) begin
        port_val[p] = '0;
      end else if (fwd_hit[p]) begin
        port_val[p] = bus.wr_data;
      end
    end
  end

  // Issue is applied after the clear so a same-cycle issue of the written register stays pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) begin
      pend_nxt[bus.wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      pend_nxt[bus.iss_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign bus.pend_cnt = cnt;

  generate
    if (READ_REG != 0) begin : g_read_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bus.rd_data0 <= '0;
          bus.rd_data1 <= '0;
          bus.rd_busy0 <= 1'b0;
          bus.rd_busy1 <= 1'b0;
        end else if (bus.rd_en) begin
          bus.rd_data0 <= port_val[0];
          bus.rd_data1 <= port_val[1];
          bus.rd_busy0 <= port_busy[0];
          bus.rd_busy1 <= port_busy[1];
        end
      end
    end else begin : g_read_comb
      // Gate with rst too, otherwise a bypassed wr_data would leak out during reset.
      logic rd_live;
      assign rd_live      = bus.rd_en && !rst;
      assign bus.rd_data0 = rd_live ? port_val[0] : '0;
      assign bus.rd_data1 = rd_live ? port_val[1] : '0;
      assign bus.rd_busy0 = rd_live && port_busy[0];
      assign bus.rd_busy1 = rd_live && port_busy[1];
    end
  endgenerate
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file for the pipelined MIPS core.
- Generalises the 32x32 two-read/one-write file in width and depth.
- Adds an optional registered read stage, write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode (read and issue) and writeback (write and clear).
- Hazard logic uses the busy outputs to stall.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 is hardwired to zero (never written, never pending)
BYPASS, 1, 1 = a same-cycle write is forwarded to any read of the same address
READ_REG, 0, 0 = combinational read; 1 = read data and busy are registered (1-cycle latency)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback register index
wr_data  input  DATA_W  writeback data
rd_en  input  1  read enable
rd_addr0  input  ADDR_W  read port 0 index
rd_addr1  input  ADDR_W  read port 1 index
iss_en  input  1  issue strobe; marks iss_addr as pending
iss_addr  input  ADDR_W  destination of the issued instruction
rd_data0  output  DATA_W  read port 0 data
rd_data1  output  DATA_W  read port 1 data
rd_busy0  output  1  rd_addr0 has an outstanding write
rd_busy1  output  1  rd_addr1 has an outstanding write
pend_cnt  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (async, rst high): all registers, all pending bits, pend_cnt, and the registered outputs go to 0 immediately. All outputs read 0 during reset.
- Write: at posedge, if wr_en is high and the address is writable, regs[wr_addr] <= wr_data.
  - An address is writable unless ZERO_REG=1 and wr_addr==0.
  - A write to reg 0 with ZERO_REG=1 is silently dropped.
- Read value per port (v):
  - 0 if ZERO_REG=1 and addr==0.
  - Otherwise wr_data if BYPASS=1, wr_en=1, the address is writable and wr_addr==addr.
  - Otherwise regs[addr].
- READ_REG=0:
  - rd_dataN = v when rd_en=1, else 0 (combinational).
- READ_REG=1:
  - At posedge with rd_en=1, rd_dataN <= v and rd_busyN <= busy.
  - With rd_en=0 the registered outputs hold their previous values.
  - When BYPASS=0, v for the registered stage is the pre-write register content.
- Scoreboard: pend[DEPTH] bits.
  - At posedge: iss_en sets pend[iss_addr]; a writable wr_en clears pend[wr_addr].
  - Same address issued and written in one cycle: the set wins (a newer producer is outstanding). pend stays 1; regs still update.
  - iss_en to reg 0 with ZERO_REG=1 is ignored.
  - iss_en to an already-pending register leaves it pending. There is no count of outstanding writes per register.
- Busy per port (READ_REG=0 value; registered copy when READ_REG=1):
  - busy = pend[addr] & ~(BYPASS & same-cycle writable write to addr).
  - Forced to 0 when rd_en=0 (combinational mode).
  - Forced to 0 for reg 0 when ZERO_REG=1.
- pend_cnt:
  - Registered popcount of pend, updated with pend at the same edge (equals popcount of pend after the edge).
  - Range 0..DEPTH, or 0..DEPTH-1 when ZERO_REG=1.
  - Never wraps.
- Both read ports may address the same register; both return identical data and busy.
- Reset asserted mid-operation discards in-flight writes and issues of that cycle.

Test Plan:
- Reset then read all 32 addresses with rd_en=1 -> every rd_data=0, busy=0, pend_cnt=0.
- Write 0xDEADBEEF to r5, next cycle read r5 on both ports -> both 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
- BYPASS=1, READ_REG=0: wr_en r7=0xA5A5A5A5 while rd_addr0=7 in the same cycle -> rd_data0=0xA5A5A5A5 that cycle and rd_busy0=0. With BYPASS=0 -> old value returned.
- Issue r3, r9, r9 (three cycles) -> pend_cnt 1,2,2 and rd_busy on r9=1. Same cycle iss r3 + wr r3 -> r3 stays pending, pend_cnt unchanged. Write r9 -> pend_cnt=1.
- READ_REG=1: write r12=0x55 then rd_addr0=12 -> rd_data0=0x55 appears one cycle after the rd_en edge. Drop rd_en -> output holds 0x55.
- Assert rst while r4=0x77 and r4 pending -> regs, pend and outputs 0 immediately. Reads after release -> 0.
